// File: rtl/scrambler_pkg.sv
// scrambler_pkg: shared types and constants for the tile scrambler
package scrambler_pkg;
   localparam int POS_COUNT = 6;
   localparam logic [7:0] LFSR_POLY = 8'hB8;
   typedef logic [2:0] pos_t;
   typedef enum logic [2:0] {IDLE, SHUFFLE, FIX, READY, SWAP} state_t;
   // map the 3-bit random value onto a legal position: 6->0, 7->1
   function automatic pos_t fold(input pos_t v);
      return (v > 3'd5) ? v - 3'd6 : v;
   endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), loads seed on reset
import scrambler_pkg::*;
module lfsr8 (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seed,
   output logic [7:0] q
);
   // right-shifting Galois form: feedback bit 0 xors the tap mask in
   always_ff @(posedge clk)
      q <= !rst ? seed : ({1'b0, q[7:1]} ^ (q[0] ? LFSR_POLY : 8'h00));
endmodule

// File: rtl/tile_scrambler.sv
// tile_scrambler: shuffles a 6-digit permutation, then applies user swaps; SCRAMBLE_DERANGE_EN rotates an identity result
import scrambler_pkg::*;
module tile_scrambler #(
   parameter int         NUM_SWAPS = 12,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       change,
   input  logic [2:0] sel_a,
   input  logic [2:0] sel_b,
   output logic [2:0] index1,
   output logic [2:0] index2,
   output logic [2:0] index3,
   output logic [2:0] index4,
   output logic [2:0] index5,
   output logic [2:0] index6,
   output logic       done,
   output logic       busy
);
   state_t     state;
   pos_t       perm [POS_COUNT];
   logic [5:0] cnt;
   pos_t       col;
   pos_t       r;
   logic       change_q;
   logic       pend;
   logic       rise;
   logic [7:0] lfsr_q;

   lfsr8 u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .q(lfsr_q));

   assign r = fold(lfsr_q[2:0]);
   assign rise = change & ~change_q;
   assign index1 = perm[0];
   assign index2 = perm[1];
   assign index3 = perm[2];
   assign index4 = perm[3];
   assign index5 = perm[4];
   assign index6 = perm[5];

`ifdef SCRAMBLE_DERANGE_EN
   logic ident;
   // flags a shuffle that ended back at identity
   always_comb begin
      ident = 1'b1;
      for (int k = 0; k < POS_COUNT; k++) if (perm[k] != pos_t'(k)) ident = 1'b0;
   end
`endif

   // control FSM with registered done/busy; perm only ever changes by swaps or whole rotations
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         done     <= 1'b0;
         busy     <= 1'b0;
         cnt      <= '0;
         col      <= '0;
         change_q <= 1'b0;
         pend     <= 1'b0;
         for (int k = 0; k < POS_COUNT; k++) perm[k] <= pos_t'(k);
      end else begin
         change_q <= change;
         if (state != IDLE && !en) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
            pend  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (en) begin
                  for (int k = 0; k < POS_COUNT; k++) perm[k] <= pos_t'(k);
                  cnt   <= '0;
                  col   <= '0;
                  busy  <= 1'b1;
                  state <= SHUFFLE;
               end
               SHUFFLE: begin
                  perm[col] <= perm[r];
                  perm[r]   <= perm[col];
                  cnt       <= cnt + 6'd1;
                  col       <= (col == 3'd5) ? 3'd0 : col + 3'd1;
                  if (cnt == 6'(NUM_SWAPS - 1)) state <= FIX;
               end
               FIX: begin
`ifdef SCRAMBLE_DERANGE_EN
                  if (ident) for (int k = 0; k < POS_COUNT; k++) perm[k] <= perm[(k + 1) % POS_COUNT];
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= READY;
               end
               READY: if (rise || pend) begin
                  pend  <= 1'b0;
                  state <= SWAP;
               end
               SWAP: begin
                  if (sel_a <= 3'd5 && sel_b <= 3'd5) begin
                     perm[sel_a] <= perm[sel_b];
                     perm[sel_b] <= perm[sel_a];
                  end
                  if (rise) pend <= 1'b1;
                  state <= READY;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/tile_scrambler.md
TILE_SCRAMBLER -- requirements
Module: tile_scrambler

Interface
REQ-001 Parameter NUM_SWAPS, default 12: swaps performed per shuffle, range 1..63.
REQ-002 Parameter LFSR_SEED, default 8'hA5: LFSR value on reset; nonzero.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 en  in  1  level request to scramble and hold a puzzle.
REQ-006 change  in  1  user swap request; acted on at its rising edge only.
REQ-007 sel_a, sel_b  in  3 each  positions to swap on change; valid range 0..5.
REQ-008 index1..index6  out  3 each  source digit index shown at positions 0..5.
REQ-009 done  out  1  high while a finished puzzle is held (READY and SWAP states).
REQ-010 busy  out  1  high during the SHUFFLE and FIX states.

Function
REQ-011 SHALL hold a 6-entry permutation perm[0..5] of 3-bit values; indexK = perm[K-1].
REQ-012 SHALL run an 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) that advances every cycle, in every state.
REQ-013 States: IDLE, SHUFFLE, FIX, READY, SWAP.
REQ-014 IDLE: done=0, busy=0; en=1 loads identity perm (0..5), clears swap counter, next state SHUFFLE.
REQ-015 SHUFFLE: each cycle swaps perm[c] with perm[r], where c = counter mod 6 and r = lfsr[2:0], folded 6->0 and 7->1; counter increments.
REQ-016 SHUFFLE exits after exactly NUM_SWAPS swap cycles, to FIX; busy=1 for NUM_SWAPS+1 cycles in total.
REQ-017 FIX: one cycle; behaviour set by REQ-026/027; next state READY.
REQ-018 READY: done=1; a detected 0->1 edge on change moves to SWAP.
REQ-019 SWAP: one cycle; if both sel_a and sel_b are <=5, exchange perm[sel_a] and perm[sel_b]; otherwise leave perm unchanged; done stays 1; next state READY.
REQ-020 sel_a equal to sel_b SHALL leave perm unchanged.
REQ-021 change edge detection SHALL use a registered copy of change; a held-high change produces exactly one swap.
REQ-022 en=0 in any non-IDLE state SHALL move to IDLE on the next edge; perm is retained, done and busy go 0.
REQ-023 en and change are ignored while in SHUFFLE/FIX, except as given by REQ-022.
REQ-024 A change edge arriving during SWAP is registered and processed after the return to READY.
REQ-025 perm SHALL always be a permutation of 0..5 under every input sequence.

Configuration
REQ-026 With SCRAMBLE_DERANGE_EN defined, FIX SHALL rotate perm left by one (perm[k] <= perm[(k+1) mod 6]) if perm equals identity; otherwise it SHALL leave perm unchanged.
REQ-027 Without SCRAMBLE_DERANGE_EN, FIX SHALL be a pass-through state, with no change to perm.

Reset
REQ-028 rst=0 at an edge SHALL force: state IDLE, perm identity (index1..6 = 0..5), done=0, busy=0, LFSR=LFSR_SEED, counter=0, registered change=0.
REQ-029 Reset during SHUFFLE or SWAP SHALL abort the operation with no partial-swap residue.

Structure
REQ-030 Package scrambler_pkg SHALL hold POS_COUNT=6, the 3-bit position type, the state enum and the LFSR polynomial constant.
REQ-031 The LFSR SHALL be a sub-module lfsr8 with ports clk, rst, seed and q.

Verification
REQ-032 Reset, then en=1 -> busy=1 for 13 cycles, then done=1 with index1..6 forming a permutation of 0..5.
REQ-033 In READY with perm known, sel_a=1, sel_b=4, pulse change -> index2 and index5 exchange, all other indices unchanged, done stays 1.
REQ-034 change held high for 10 cycles with sel_a=0, sel_b=5 -> exactly one swap; sel_a=6 -> no change.
REQ-035 en dropped mid-SHUFFLE -> IDLE next cycle, busy=0; rst=0 mid-SHUFFLE -> indices 0..5.
REQ-036 SCRAMBLE_DERANGE_EN defined, NUM_SWAPS=1 with a seed forcing a swap of perm[0] with itself -> index1..6 = 1,2,3,4,5,0; without the macro -> 0..5.
REQ-037 Random 10k-cycle run of en, change and sel values -> REQ-025 assertion never fails.
